// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer readout engine.
package fb_pkg;

  localparam int FB_WIDTH_DEF  = 320;
  localparam int FB_HEIGHT_DEF = 180;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FETCH,
    DONE
  } fb_readout_state_t;

  // First address of a framebuffer page; page 1 sits directly after page 0.
  function automatic int unsigned page_base(input logic pg, input int unsigned w,
                                            input int unsigned h);
    return pg ? (w * h) : 32'd0;
  endfunction

endpackage

// File: rtl/delay_sr.sv
// Fixed-depth shift register used to match BRAM read latency.
module delay_sr #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk_sys,
  input  logic             rst_sys_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_reg [DEPTH];

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
    end else begin
      stage_reg[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/fb_readout.sv
// Framebuffer row readout with vertical scaling and BRAM latency matching.
// Define FB_READOUT_DBUF_EN for double-buffered page flipping.
module fb_readout
  import fb_pkg::*;
#(
  parameter int FB_WIDTH  = FB_WIDTH_DEF,
  parameter int FB_HEIGHT = FB_HEIGHT_DEF,
  parameter int ADDRW     = 17,
  parameter int SCALEW    = 6,
  parameter int BRAM_LAT  = 1
) (
  input  logic              clk_sys,
  input  logic              rst_sys_n,
  input  logic              frame_sys,
  input  logic              line_sys,
  input  logic              line0_sys,
  input  logic [SCALEW-1:0] scale,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              page,
  output logic [ADDRW-1:0]  fb_addr_read,
  output logic              fb_re,
  output logic              lb_en_in,
  output logic              frame_done,
  output logic              overrun
);

  localparam int PIXW = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
  localparam int ROWW = $clog2(FB_HEIGHT + 1);
  localparam logic [PIXW-1:0]  LAST_PIX = PIXW'(FB_WIDTH - 1);
  localparam logic [ROWW-1:0]  LAST_ROW = ROWW'(FB_HEIGHT - 1);
  localparam logic [ADDRW-1:0] ROW_STEP = ADDRW'(FB_WIDTH);

  fb_readout_state_t state_reg, state_next;
  logic [SCALEW-1:0] scale_m1_reg, scale_m1_next;
  logic [SCALEW-1:0] line_cnt_reg, line_cnt_next;
  logic [ROWW-1:0]   row_cnt_reg, row_cnt_next;
  logic [PIXW-1:0]   pix_cnt_reg, pix_cnt_next;
  logic [ADDRW-1:0]  row_base_reg, row_base_next;
  logic [ADDRW-1:0]  addr_reg, addr_next;
  logic              page_reg, page_next;
  logic              swap_ack_reg, swap_ack_next;
  logic              overrun_reg, overrun_next;
  logic [ADDRW-1:0]  base_now;

`ifdef FB_READOUT_DBUF_EN
  assign base_now = ADDRW'(page_base(page_reg, FB_WIDTH, FB_HEIGHT));
`else
  logic unused_swap_req;
  assign unused_swap_req = swap_req;
  assign base_now        = '0;
`endif

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_reg    <= IDLE;
      scale_m1_reg <= '0;
      line_cnt_reg <= '0;
      row_cnt_reg  <= '0;
      pix_cnt_reg  <= '0;
      row_base_reg <= '0;
      addr_reg     <= '0;
      page_reg     <= 1'b0;
      swap_ack_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      scale_m1_reg <= scale_m1_next;
      line_cnt_reg <= line_cnt_next;
      row_cnt_reg  <= row_cnt_next;
      pix_cnt_reg  <= pix_cnt_next;
      row_base_reg <= row_base_next;
      addr_reg     <= addr_next;
      page_reg     <= page_next;
      swap_ack_reg <= swap_ack_next;
      overrun_reg  <= overrun_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    scale_m1_next = scale_m1_reg;
    line_cnt_next = line_cnt_reg;
    row_cnt_next  = row_cnt_reg;
    pix_cnt_next  = pix_cnt_reg;
    row_base_next = row_base_reg;
    addr_next     = addr_reg;
    page_next     = page_reg;
    swap_ack_next = 1'b0;
    overrun_next  = overrun_reg;
    fb_re         = 1'b0;

    if (frame_sys) begin
      state_next    = IDLE;
      scale_m1_next = (scale == '0) ? '0 : scale - 1'b1;
      line_cnt_next = '0;
      row_cnt_next  = '0;
      overrun_next  = 1'b0;
`ifdef FB_READOUT_DBUF_EN
      if (swap_req) begin
        page_next     = ~page_reg;
        swap_ack_next = 1'b1;
      end
`endif
    end else if (line0_sys) begin
      row_base_next = base_now;
      addr_next     = base_now;
      row_cnt_next  = '0;
      line_cnt_next = '0;
      pix_cnt_next  = '0;
      state_next    = FETCH;
    end else if (line_sys && (state_reg == WAIT || state_reg == FETCH)) begin
      // A line boundary inside a fetch drops the rest of the row.
      if (state_reg == FETCH) overrun_next = 1'b1;
      if (line_cnt_reg == scale_m1_reg) begin
        line_cnt_next = '0;
        row_cnt_next  = row_cnt_reg + 1'b1;
        row_base_next = row_base_reg + ROW_STEP;
        if (row_cnt_reg == LAST_ROW) begin
          state_next = DONE;
        end else begin
          addr_next    = row_base_reg + ROW_STEP;
          pix_cnt_next = '0;
          state_next   = FETCH;
        end
      end else begin
        line_cnt_next = line_cnt_reg + 1'b1;
        state_next    = WAIT;
      end
    end else if (state_reg == FETCH) begin
      fb_re = 1'b1;
      if (pix_cnt_reg == LAST_PIX) begin
        state_next = WAIT;
      end else begin
        pix_cnt_next = pix_cnt_reg + 1'b1;
        addr_next    = addr_reg + 1'b1;
      end
    end
  end

  delay_sr #(
    .DEPTH(BRAM_LAT),
    .WIDTH(1)
  ) u_lb_delay (
    .clk_sys  (clk_sys),
    .rst_sys_n(rst_sys_n),
    .din      (fb_re),
    .dout     (lb_en_in)
  );

  assign fb_addr_read = addr_reg;
  assign page         = page_reg;
  assign swap_ack     = swap_ack_reg;
  assign overrun      = overrun_reg;
  assign frame_done   = (state_reg == DONE);

endmodule

// File: tb/tb_fb_readout.sv
// Table-driven bench for fb_readout with an address scoreboard on fb_re.
module tb_fb_readout;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int AW  = 17;
  localparam int SW  = 6;
  localparam int LAT = 1;
  localparam int GAP = 10;
`ifdef FB_READOUT_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic          clk_sys   = 1'b0;
  logic          rst_sys_n = 1'b0;
  logic          frame_sys = 1'b0;
  logic          line_sys  = 1'b0;
  logic          line0_sys = 1'b0;
  logic          swap_req  = 1'b0;
  logic [SW-1:0] scale     = '0;
  logic          swap_ack, page, fb_re, lb_en_in, frame_done, overrun;
  logic [AW-1:0] fb_addr_read;

  int checks   = 0;
  int failures = 0;
  int reads    = 0;
  int exp_q[$];
  bit hist[4];
  bit exp_page = 1'b0;

  typedef struct {
    int scale;
    bit swap;
    bit midswap;
    int nlines;
    int exp_reads;
    bit exp_done;
  } vec_t;
  vec_t vecs[8];

  always #5 clk_sys = ~clk_sys;

  fb_readout #(
    .FB_WIDTH (W),
    .FB_HEIGHT(H),
    .ADDRW    (AW),
    .SCALEW   (SW),
    .BRAM_LAT (LAT)
  ) dut (
    .clk_sys     (clk_sys),
    .rst_sys_n   (rst_sys_n),
    .frame_sys   (frame_sys),
    .line_sys    (line_sys),
    .line0_sys   (line0_sys),
    .scale       (scale),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .page        (page),
    .fb_addr_read(fb_addr_read),
    .fb_re       (fb_re),
    .lb_en_in    (lb_en_in),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end else begin
      $display("ok   %s value=%0d t=%0t", name, act, $time);
    end
  endtask

  task automatic cyc;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic step(input bit f, input bit l0, input bit l);
    frame_sys = f;
    line0_sys = l0;
    line_sys  = l;
    cyc();
    frame_sys = 1'b0;
    line0_sys = 1'b0;
    line_sys  = 1'b0;
  endtask

  function automatic int page_off();
    return int'(exp_page) * W * H;
  endfunction

  task automatic push_row(input int row);
    for (int c = 0; c < W; c++) exp_q.push_back(page_off() + row * W + c);
  endtask

  // Scoreboard: every fb_re pops one expected address; lb_en_in trails fb_re.
  always @(negedge clk_sys) begin
    if (!rst_sys_n) begin
      for (int i = 0; i < 4; i++) hist[i] <= 1'b0;
    end else begin
      chk("lb_en_in", lb_en_in, hist[LAT-1]);
      for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
      hist[0] <= fb_re;
      if (fb_re) begin
        reads <= reads + 1;
        if (exp_q.size() == 0) chk("fb_re_unexpected", fb_re, 0);
        else chk("fb_addr_read", fb_addr_read, exp_q.pop_front());
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int s;
    int r0;
    s        = (v.scale == 0) ? 1 : v.scale;
    scale    = SW'(v.scale);
    swap_req = v.swap;
    step(1'b1, 1'b0, 1'b0);
    swap_req = 1'b0;
    if (DBUF && v.swap) exp_page = ~exp_page;
    chk("swap_ack", swap_ack, DBUF && v.swap);
    chk("page", page, exp_page);
    chk("frame_done_clr", frame_done, 0);
    chk("overrun_clr", overrun, 0);
    cyc();
    chk("swap_ack_pulse", swap_ack, 0);
    r0 = reads;
    push_row(0);
    step(1'b0, 1'b1, 1'b0);
    if (v.midswap) swap_req = 1'b1;
    repeat (GAP) cyc();
    for (int k = 1; k <= v.nlines; k++) begin
      if ((k % s) == 0 && (k / s) < H) push_row(k / s);
      step(1'b0, 1'b0, 1'b1);
      repeat (GAP) cyc();
    end
    chk("reads", reads - r0, v.exp_reads);
    chk("frame_done", frame_done, v.exp_done);
    chk("overrun", overrun, 0);
    chk("pending", exp_q.size(), 0);
    chk("page_hold", page, exp_page);
  endtask

  initial begin
    int r0;
    vecs[0] = '{1, 1'b0, 1'b0, 3, 12, 1'b1};
    vecs[1] = '{2, 1'b0, 1'b0, 6, 12, 1'b1};
    vecs[2] = '{1, 1'b1, 1'b1, 3, 12, 1'b1};
    vecs[3] = '{0, 1'b0, 1'b0, 3, 12, 1'b1};
    vecs[4] = '{2, 1'b0, 1'b0, 5, 12, 1'b0};
    vecs[5] = '{3, 1'b1, 1'b0, 3, 8,  1'b0};
    vecs[6] = '{1, 1'b0, 1'b0, 2, 12, 1'b0};
    vecs[7] = '{1, 1'b0, 1'b0, 0, 4,  1'b0};

    // Reset values, then a stray line_sys while idle must not fetch
    repeat (3) cyc();
    chk("rst_fb_re", fb_re, 0);
    chk("rst_lb_en", lb_en_in, 0);
    chk("rst_addr", fb_addr_read, 0);
    chk("rst_page", page, 0);
    chk("rst_frame_done", frame_done, 0);
    rst_sys_n = 1'b1;
    cyc();
    step(1'b0, 1'b0, 1'b1);
    repeat (GAP) cyc();
    chk("idle_reads", reads, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Line arriving two reads into a fetch
    scale = SW'(1);
    step(1'b1, 1'b0, 1'b0);
    r0 = reads;
    exp_q.push_back(page_off());
    exp_q.push_back(page_off() + 1);
    step(1'b0, 1'b1, 1'b0);
    cyc();
    cyc();
    push_row(1);
    step(1'b0, 1'b0, 1'b1);
    repeat (GAP) cyc();
    chk("abort_reads", reads - r0, 2 + W);
    chk("abort_overrun", overrun, 1);
    chk("abort_pending", exp_q.size(), 0);
    step(1'b1, 1'b0, 1'b0);
    chk("overrun_cleared", overrun, 0);

    // frame_sys and line_sys together mid-fetch
    r0 = reads;
    exp_q.push_back(page_off());
    step(1'b0, 1'b1, 1'b0);
    cyc();
    step(1'b1, 1'b0, 1'b1);
    repeat (GAP) cyc();
    chk("frame_line_reads", reads - r0, 1);
    chk("frame_line_done", frame_done, 0);
    chk("frame_line_overrun", overrun, 0);

    // Async reset mid-fetch
    exp_q.push_back(page_off());
    step(1'b0, 1'b1, 1'b0);
    cyc();
    rst_sys_n = 1'b0;
    #1;
    exp_page = 1'b0;
    chk("arst_fb_re", fb_re, 0);
    chk("arst_lb_en", lb_en_in, 0);
    chk("arst_addr", fb_addr_read, 0);
    chk("arst_page", page, exp_page);
    chk("arst_swap_ack", swap_ack, 0);
    chk("arst_overrun", overrun, 0);
    repeat (3) cyc();
    rst_sys_n = 1'b1;
    cyc();
    chk("arst_pending", exp_q.size(), 0);

    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_readout.md
# fb_readout

Parametrised framebuffer readout engine in the system clock domain. It generates bitmap read addresses and linebuffer write enables for each framebuffer row, repeating rows for a runtime vertical scale. It compensates for BRAM read latency and supports double-buffered page flipping. It sits between the framebuffer BRAM read port and the linebuffer input, driven by the frame, line and first-line flags already crossed into the system domain.

## Interface
- FB_WIDTH, 320: framebuffer width in pixels
- FB_HEIGHT, 180: framebuffer height in pixels
- ADDRW, 17: read address width; must hold 2*FB_WIDTH*FB_HEIGHT-1
- SCALEW, 6: scale input width
- BRAM_LAT, 1: BRAM read latency in cycles (1-4)

- clk_sys  in  1  system clock
- rst_sys_n  in  1  asynchronous active-low reset
- frame_sys  in  1  frame-start pulse
- line_sys  in  1  line-start pulse
- line0_sys  in  1  pulse at start of first framebuffer display line
- scale  in  SCALEW  vertical scale, sampled at frame_sys; 0 is treated as 1
- swap_req  in  1  level; request page flip at next frame
- swap_ack  out  1  one-cycle pulse when a flip takes effect
- page  out  1  page currently being read
- fb_addr_read  out  ADDRW  BRAM read address
- fb_re  out  1  read issued this cycle
- lb_en_in  out  1  read data valid for linebuffer; fb_re delayed BRAM_LAT cycles
- frame_done  out  1  high from last row fetched until next frame_sys
- overrun  out  1  sticky; a fetch was cut short by line_sys; cleared at frame_sys

## Operation
- FSM states: IDLE, WAIT, FETCH, DONE.
- Reset state is IDLE. On reset all outputs are 0, page is 0, and the BRAM_LAT delay line is cleared.
- frame_sys (any state) does the following:
  - enter IDLE
  - latch scale
  - zero the row counter, line counter and overrun
  - if swap_req: toggle page and pulse swap_ack in the same cycle
- IDLE + line0_sys: set row base to the page base (0 or FB_WIDTH*FB_HEIGHT), line count to 0, then go to FETCH.
- FETCH: issue FB_WIDTH reads on consecutive cycles with fb_re=1, starting at fb_addr_read = row base and incrementing by 1. After the last read go to WAIT.
- line_sys in WAIT or FETCH: the line count increments and wraps at scale-1.
  - On wrap the row base advances by FB_WIDTH and the row counter increments.
  - If the row counter has reached FB_HEIGHT, go to DONE.
  - Otherwise, on wrap, go to FETCH for the new row. Non-wrap lines stay in WAIT; the linebuffer repeats the previous row.
- line_sys during FETCH aborts the remaining reads, sets overrun, and is then handled as above.
- Row base is an accumulator: add FB_WIDTH per row, with no multiplier.
- DONE: fb_re=0 and frame_done=1 until frame_sys.

## Timing
- First fb_re is on the cycle after line0_sys or the wrapping line_sys.
- lb_en_in equals fb_re delayed exactly BRAM_LAT cycles. lb_en_in pulses already in the delay line still drain after an abort or frame_sys.
- Simultaneous events:
  - frame_sys beats line0_sys and line_sys.
  - line0_sys beats line_sys and forces a restart at row 0.
- swap_req sampled on any cycle other than frame_sys has no effect. page never changes mid-frame.
- fb_addr_read holds its last value while fb_re=0.
- When the reset deasserts, the first action waits for frame_sys or line0_sys.

## Configuration
- FB_READOUT_DBUF_EN defined: page flip as described; ADDRW covers two pages.
- Not defined: page is tied to 0 and swap_ack to 0; swap_req is ignored; page base is always 0 and ADDRW need only cover one page.

## Structure
- The shared package `fb_pkg` holds:
  - the FSM state enum `fb_readout_state_t`
  - FB_WIDTH/FB_HEIGHT defaults
  - the page-base constant function
- One sub-module, `delay_sr`: a parametrised-depth shift register for the fb_re→lb_en_in delay. It is reusable for address-latency matching.

## Test plan
- FB_WIDTH=4, FB_HEIGHT=3, scale=1, BRAM_LAT=1: frame, line0, then line every 10 cycles -> addresses 0-3, 4-7, 8-11; lb_en_in trails fb_re by 1 cycle; frame_done after the third row's line.
- scale=2: 6 line pulses after line0 -> fetches only on lines 0, 2, 4 (rows 0, 1, 2); no fb_re on odd lines.
- swap_req=1 at the frame pulse -> swap_ack one cycle, page=1, first address 12. swap_req raised mid-frame -> no change until the next frame.
- line_sys 2 cycles into a fetch -> only 2 reads issued, overrun=1, next row starts at address 4; overrun clears at the next frame_sys.
- frame_sys and line_sys in the same cycle mid-FETCH -> IDLE, no further fb_re. Async reset asserted mid-FETCH -> all outputs 0 immediately, page 0.
- scale=0 -> behaves identically to scale=1.
